seq_binary_to_bcd: RTL and testbench

- Multi-cycle, parametrised binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Adds valid/ready handshakes on input and output, optional two's-complement input, and overflow saturation.
- Sits between the calculator's arithmetic core and the display driver.
- Output format is {sign, digit[DIGITS-1] .. digit[0]}.

---
 rtl/seq_binary_to_bcd.sv | 84 ++++++++
 tb/tb_seq_binary_to_bcd.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seq_binary_to_bcd.sv
// seq_binary_to_bcd: one-bit-per-clock double-dabble converter with handshakes and saturation; LEADING_ZERO_BLANK_EN blanks leading zeros
module seq_binary_to_bcd #(
  parameter int BIN_W = 20,
  parameter int DIGITS = 6,
  parameter int SIGNED_IN = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inValid,
  output logic                inReady,
  input  logic [BIN_W-1:0]    binIn,
  input  logic                signIn,
  output logic                outValid,
  input  logic                outReady,
  output logic [4*DIGITS:0]   bcdOut,
  output logic                overflow
);
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [BIN_W-1:0] mag, cap_mag;
  logic [4*DIGITS-1:0] dig, adj, sat;
  logic sgn, ovf, cap_sgn, res_ovf;
  logic [4*DIGITS:0] res;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign adj[4*i+:4] = dig[4*i+:4] >= 4'd5 ? dig[4*i+:4] + 4'd3 : dig[4*i+:4];
  end
  // operand capture, saturation and next-state selection
  always_comb begin
    cap_sgn = SIGNED_IN != 0 ? binIn[BIN_W-1] : signIn;
    cap_mag = (SIGNED_IN != 0 && binIn[BIN_W-1]) ? -binIn : binIn;
    sat = ovf ? {DIGITS{4'h9}} : dig;
    state_n = state == IDLE ? (inValid ? CONVERT : IDLE) :
              state == CONVERT ? (cnt == '0 ? DONE : CONVERT) :
              (outReady ? IDLE : DONE);
  end
  assign inReady = state == IDLE;
  assign outValid = state == DONE;
  assign overflow = res_ovf;
  // shift-add-3 datapath; the zero-count cycle latches the saturated, sign-cleaned result
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      mag <= '0;
      dig <= '0;
      sgn <= 1'b0;
      ovf <= 1'b0;
      res <= '0;
      res_ovf <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && inValid) begin
        sgn <= cap_sgn;
        mag <= cap_mag;
        dig <= '0;
        ovf <= 1'b0;
        cnt <= CW'(BIN_W);
      end else if (state == CONVERT && cnt != '0) begin
        {dig, mag} <= {adj[4*DIGITS-2:0], mag, 1'b0};
        ovf <= ovf | adj[4*DIGITS-1];
        cnt <= cnt - 1'b1;
      end else if (state == CONVERT) begin
        res <= {sgn & |sat, sat};
        res_ovf <= ovf;
      end
    end
  end
`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
  // blank zero digits above the most significant nonzero one while presenting a result
  always_comb begin
    bcdOut = res;
    lead = state == DONE;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead = lead && res[4*i+:4] == 4'h0;
      if (lead) bcdOut[4*i+:4] = 4'hF;
    end
  end
`else
  assign bcdOut = res;
`endif
endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// tb_seq_binary_to_bcd: directed checks of the default unsigned converter and a 21-bit signed instance
module tb_seq_binary_to_bcd;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid0 = 1'b0, sign0 = 1'b0, out_ready0 = 1'b0;
  logic [19:0] bin0 = '0;
  logic ready0, valid0, ovf0;
  logic [24:0] bcd0;
  logic in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [20:0] bin1 = '0;
  logic ready1, valid1, ovf1;
  logic [24:0] bcd1;
  int checks = 0;
  int failures = 0;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [24:0] E0 = 25'h0FFFFF0, E42 = 25'h0FFFF42, E12345S = 25'h1F12345;
  localparam logic [24:0] E500 = 25'h0FFF500, E7 = 25'h0FFFFF7;
`else
  localparam logic [24:0] E0 = 25'h0000000, E42 = 25'h0000042, E12345S = 25'h1012345;
  localparam logic [24:0] E500 = 25'h0000500, E7 = 25'h0000007;
`endif
  localparam logic [19:0] VB [6] = '{20'd998001, 20'd1000000, 20'd999999, 20'd0, 20'd42, 20'd12345};
  localparam logic VS [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [24:0] VE [6] = '{25'h0998001, 25'h0999999, 25'h0999999, E0, E42, E12345S};
  localparam logic VO [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] SB [3] = '{21'h1FCFC7, 21'h100000, 21'd500};
  localparam logic [24:0] SE [3] = '{E12345S, 25'h1999999, E500};
  localparam logic SO [3] = '{1'b0, 1'b1, 1'b0};

  seq_binary_to_bcd u0 (
    .clk(clk), .reset(reset), .inValid(in_valid0), .inReady(ready0), .binIn(bin0), .signIn(sign0),
    .outValid(valid0), .outReady(out_ready0), .bcdOut(bcd0), .overflow(ovf0)
  );
  seq_binary_to_bcd #(.BIN_W(21), .DIGITS(6), .SIGNED_IN(1)) u1 (
    .clk(clk), .reset(reset), .inValid(in_valid1), .inReady(ready1), .binIn(bin1), .signIn(1'b0),
    .outValid(valid1), .outReady(out_ready1), .bcdOut(bcd1), .overflow(ovf1)
  );

  always #5 clk = ~clk;

  task automatic start0(input logic [19:0] b, input logic s, output int lat);
    int w = 0;
    while (!ready0 && w < 200) begin @(negedge clk); w++; end
    bin0 = b; sign0 = s; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    lat = 0;
    while (!valid0 && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic ack0;
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL reset_inready got=%b exp=1", ready0); end
    checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL reset_outvalid got=%b exp=0", valid0); end
    checks++; if (bcd0 !== 25'h0) begin failures++; $display("FAIL reset_bcd got=%h exp=0000000", bcd0); end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", ovf0); end
    checks++; if (ready1 !== 1'b1 || valid1 !== 1'b0) begin failures++; $display("FAIL reset_signed_hs got=%b%b exp=10", ready1, valid1); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_convert;
    int lat;
    for (int i = 0; i < 6; i++) begin
      start0(VB[i], VS[i], lat);
      checks++; if (lat != 21) begin failures++; $display("FAIL conv%0d_latency got=%0d exp=21", i, lat); end
      checks++; if (bcd0 !== VE[i]) begin failures++; $display("FAIL conv%0d_bcd got=%h exp=%h", i, bcd0, VE[i]); end
      checks++; if (ovf0 !== VO[i]) begin failures++; $display("FAIL conv%0d_overflow got=%b exp=%b", i, ovf0, VO[i]); end
      ack0;
    end
  endtask

  task automatic test_signed;
    int lat;
    for (int i = 0; i < 3; i++) begin
      bin1 = SB[i]; in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      lat = 0;
      while (!valid1 && lat < 100) begin @(negedge clk); lat++; end
      checks++; if (lat != 22) begin failures++; $display("FAIL signed%0d_latency got=%0d exp=22", i, lat); end
      checks++; if (bcd1 !== SE[i]) begin failures++; $display("FAIL signed%0d_bcd got=%h exp=%h", i, bcd1, SE[i]); end
      checks++; if (ovf1 !== SO[i]) begin failures++; $display("FAIL signed%0d_overflow got=%b exp=%b", i, ovf1, SO[i]); end
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_stall;
    int lat;
    start0(20'd271828, 1'b0, lat);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin bin0 = 20'd7; in_valid0 = 1'b1; end
      @(negedge clk);
      in_valid0 = 1'b0;
      checks++; if (valid0 !== 1'b1 || ready0 !== 1'b0) begin failures++; $display("FAIL stall%0d_hs got=%b%b exp=10", c, valid0, ready0); end
      checks++; if (bcd0 !== 25'h0271828) begin failures++; $display("FAIL stall%0d_bcd got=%h exp=0271828", c, bcd0); end
    end
    ack0;
    checks++; if (valid0 !== 1'b0 || ready0 !== 1'b1) begin failures++; $display("FAIL stall_release_hs got=%b%b exp=01", valid0, ready0); end
    checks++; if (bcd0 !== 25'h0271828) begin failures++; $display("FAIL stall_retain_bcd got=%h exp=0271828", bcd0); end
    start0(20'd7, 1'b0, lat);
    checks++; if (lat != 21) begin failures++; $display("FAIL stall_next_latency got=%0d exp=21", lat); end
    checks++; if (bcd0 !== E7) begin failures++; $display("FAIL stall_next_bcd got=%h exp=%h", bcd0, E7); end
    ack0;
  endtask

  task automatic test_reset_mid;
    int lat;
    bin0 = 20'd123456; sign0 = 1'b1; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (valid0 !== 1'b0 || ready0 !== 1'b1) begin failures++; $display("FAIL midreset_hs got=%b%b exp=01", valid0, ready0); end
    checks++; if (bcd0 !== 25'h0 || ovf0 !== 1'b0) begin failures++; $display("FAIL midreset_bcd got=%h/%b exp=0000000/0", bcd0, ovf0); end
    start0(20'd314159, 1'b0, lat);
    checks++; if (lat != 21) begin failures++; $display("FAIL midreset_next_latency got=%0d exp=21", lat); end
    checks++; if (bcd0 !== 25'h0314159) begin failures++; $display("FAIL midreset_next_bcd got=%h exp=0314159", bcd0); end
    ack0;
  endtask

  initial begin
    test_reset;
    test_convert;
    test_signed;
    test_stall;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
